// File: rtl/i2s_sample_fetcher_pkg.sv
// Shared types and constants for the I2S sample fetcher: FSM states, widths,
// the silence value and the little-endian byte selector.
package i2s_pkg;

    localparam int SAMPLE_W = 8;
    localparam int ADDR_W   = 24;
    localparam int MEM_W    = 16;

    localparam logic [SAMPLE_W-1:0] SILENCE = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        RD_ISSUE,
        RD_WAIT,
        RESPOND
    } fetch_state_t;

    // Byte 0 of the memory word lives at the even byte address.
    function automatic logic [SAMPLE_W-1:0] sel_byte(input logic [MEM_W-1:0] word,
                                                     input logic            odd);
        return odd ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/i2s_sample_fetcher_sync_2ff.sv
// Two-flop single-bit synchronizer used to bring the sclk-domain request into clk.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic ff1_q;
    logic ff2_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;

endmodule

// File: rtl/i2s_sample_fetcher.sv
// Fetches 8-bit PCM samples for the I2S transmitter from a 16-bit Avalon-MM memory
// through a one-word cache. Optional read timeout enabled by `define FETCH_TIMEOUT_EN.
module i2s_sample_fetcher
    import i2s_pkg::*;
#(
    parameter logic [ADDR_W-1:0] END_ADDR       = 24'hFFFFFF,
    parameter int                TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req,
    input  logic [ADDR_W-1:0]   addr,
    output logic                ack,
    output logic                valid,
    output logic [SAMPLE_W-1:0] sample,
    output logic [ADDR_W-2:0]   avm_address,
    output logic                avm_read,
    input  logic                avm_waitrequest,
    input  logic [MEM_W-1:0]    avm_readdata,
    input  logic                avm_readdatavalid,
    output logic                fetch_err
);

    logic                req_s;
    logic                req_q;
    logic                rise;
    logic                pend_q;
    fetch_state_t        state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [MEM_W-1:0]    cache_q;
    logic [ADDR_W-2:0]   tag_q;
    logic                cache_vld_q;
    logic                ack_q;
    logic                valid_q;
    logic [SAMPLE_W-1:0] sample_q;
    logic                avm_read_q;
    logic [ADDR_W-2:0]   avm_addr_q;

    sync_2ff u_req_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (req),
        .q_o     (req_s)
    );

    assign rise = req_s & ~req_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;
    logic             tmo_fire;

    // Data arriving on the last allowed cycle still wins over the timeout.
    assign tmo_fire = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) &&
                      ((state_q == RD_ISSUE) || (state_q == RD_WAIT && !avm_readdatavalid));
    assign fetch_err = err_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign fetch_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_q       <= 1'b0;
            pend_q      <= 1'b0;
            state_q     <= IDLE;
            cache_vld_q <= 1'b0;
            ack_q       <= 1'b0;
            valid_q     <= 1'b0;
            sample_q    <= SILENCE;
            avm_read_q  <= 1'b0;
            avm_addr_q  <= '0;
`ifdef FETCH_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            req_q <= req_s;
            case (state_q)
                IDLE: begin
                    if (rise || pend_q) begin
                        addr_q  <= addr;
                        ack_q   <= 1'b1;
                        valid_q <= 1'b0;
                        pend_q  <= 1'b0;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (addr_q >= END_ADDR) begin
                        sample_q <= SILENCE;
                        state_q  <= RESPOND;
                    end else if (cache_vld_q && tag_q == addr_q[ADDR_W-1:1]) begin
                        sample_q <= sel_byte(cache_q, addr_q[0]);
                        state_q  <= RESPOND;
                    end else begin
                        avm_addr_q <= addr_q[ADDR_W-1:1];
                        avm_read_q <= 1'b1;
                        state_q    <= RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    if (!avm_waitrequest) begin
                        avm_read_q <= 1'b0;
                        state_q    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (avm_readdatavalid) begin
                        cache_q     <= avm_readdata;
                        tag_q       <= addr_q[ADDR_W-1:1];
                        cache_vld_q <= 1'b1;
                        sample_q    <= sel_byte(avm_readdata, addr_q[0]);
                        state_q     <= RESPOND;
                    end
                end
                RESPOND: begin
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
`ifdef FETCH_TIMEOUT_EN
            if (state_q == LOOKUP) begin
                tmo_q <= '0;
            end else if (state_q == RD_ISSUE || state_q == RD_WAIT) begin
                tmo_q <= tmo_q + 1'b1;
            end
            if (tmo_fire) begin
                avm_read_q  <= 1'b0;
                sample_q    <= SILENCE;
                err_q       <= 1'b1;
                cache_vld_q <= 1'b0;
                state_q     <= RESPOND;
            end
`endif
            // Only one request can wait behind the current one; extra edges are lost.
            if (rise && state_q != IDLE) begin
                pend_q <= 1'b1;
            end
            if (!req_s) begin
                ack_q <= 1'b0;
            end
        end
    end

    assign ack         = ack_q;
    assign valid       = valid_q;
    assign sample      = sample_q;
    assign avm_read    = avm_read_q;
    assign avm_address = avm_addr_q;

endmodule
